pipelined_carry_select_adder: RTL

//  Parametrised, pipelined carry-select adder/subtractor with valid/ready handshakes on both sides.

---
 rtl/arith_pkg.sv | 17 +
 rtl/csa_slice.sv | 35 +++
 rtl/pipelined_carry_select_adder.sv | 93 +++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared constants and helpers for the pipelined carry-select adder.
// Stage registers are kept as parallel packed arrays (sum_lo, carry, a_hi, b_hi, valid) rather than structs.
package arith_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_BLOCK = 4;

  // Legal geometry: slices tile the operand exactly.
  function automatic bit width_ok(input int width, input int block);
    return (block >= 1) && (block <= width) && ((width % block) == 0);
  endfunction

  function automatic int num_blocks(input int width, input int block);
    return width / block;
  endfunction

endpackage

// File: rtl/csa_slice.sv
// One carry-select slice: two ripple chains (carry-in 0 and 1) and a select mux on the incoming carry.
module csa_slice #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             sel_carry,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [BLOCK:0]   c0, c1;
  logic [BLOCK-1:0] s0, s1;

  always_comb begin
    c0    = '0;
    c1    = '0;
    s0    = '0;
    s1    = '0;
    c1[0] = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      s0[i]   = a[i] ^ b[i] ^ c0[i];
      c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
      s1[i]   = a[i] ^ b[i] ^ c1[i];
      c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
    end
  end

  // Carry into the slice MSB is kept so the top slice can derive signed overflow.
  assign sum      = sel_carry ? s1 : s0;
  assign cout     = sel_carry ? c1[BLOCK]   : c0[BLOCK];
  assign c_msb_in = sel_carry ? c1[BLOCK-1] : c0[BLOCK-1];

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one BLOCK-wide carry-select slice resolved per stage,
// with a single global advance so the whole pipe stalls together under backpressure.
module pipelined_carry_select_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NUM_BLOCKS = num_blocks(WIDTH, BLOCK);

  if (!width_ok(WIDTH, BLOCK)) begin : g_bad_geometry
    $error("pipelined_carry_select_adder: WIDTH must be a positive multiple of BLOCK");
  end

  // Register k holds the operands still to be consumed (shifted so slice k sits at bit 0),
  // the carry into slice k, and sum_r[k] holds slices 0..k-1 packed at the top.
  logic [NUM_BLOCKS:0]                  vld_pipe;
  logic [NUM_BLOCKS:0]                  carry_r;
  logic [NUM_BLOCKS-1:0][WIDTH-1:0]     a_r, b_r;
  logic [NUM_BLOCKS:1][WIDTH-1:0]       sum_r;
  logic                                 ovf_r;

  logic [NUM_BLOCKS-1:0][BLOCK-1:0]     slice_sum;
  logic [NUM_BLOCKS-1:0]                slice_cout, slice_cmsb;
  logic [NUM_BLOCKS:1][WIDTH-1:0]       sum_nxt;

  logic adv;
  assign adv      = !vld_pipe[NUM_BLOCKS] || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_stage
    csa_slice #(.BLOCK(BLOCK)) u_slice (
      .a         (a_r[k][BLOCK-1:0]),
      .b         (b_r[k][BLOCK-1:0]),
      .sel_carry (carry_r[k]),
      .sum       (slice_sum[k]),
      .cout      (slice_cout[k]),
      .c_msb_in  (slice_cmsb[k])
    );
    // New slice enters at the top; after the last stage every slice has shifted into place.
    if (k == 0) begin : g_first
      assign sum_nxt[1] = WIDTH'({slice_sum[0], {WIDTH{1'b0}}} >> BLOCK);
    end else begin : g_rest
      assign sum_nxt[k+1] = WIDTH'({slice_sum[k], sum_r[k]} >> BLOCK);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      carry_r  <= '0;
      a_r      <= '0;
      b_r      <= '0;
      sum_r    <= '0;
      ovf_r    <= 1'b0;
    end else if (adv) begin
      vld_pipe   <= {vld_pipe[NUM_BLOCKS-1:0], in_valid};
      a_r[0]     <= a;
      b_r[0]     <= b ^ {WIDTH{sub}};
      carry_r[0] <= sub | cin;
      for (int k = 1; k < NUM_BLOCKS; k++) begin
        a_r[k] <= a_r[k-1] >> BLOCK;
        b_r[k] <= b_r[k-1] >> BLOCK;
      end
      for (int k = 1; k <= NUM_BLOCKS; k++) begin
        carry_r[k] <= slice_cout[k-1];
        sum_r[k]   <= sum_nxt[k];
      end
      ovf_r <= slice_cout[NUM_BLOCKS-1] ^ slice_cmsb[NUM_BLOCKS-1];
    end
  end

  assign out_valid = vld_pipe[NUM_BLOCKS];
  assign sum       = sum_r[NUM_BLOCKS];
  assign cout      = carry_r[NUM_BLOCKS];
  assign overflow  = ovf_r;

endmodule
